// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter with round-robin on every ack and a per-grant ack timeout.
// Master 0 is the J1 code bus and master 1 is the J1 data bus. Both share one slave.
module wb_arbiter2 #(
    parameter int unsigned TO_CYCLES = 64
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_ni,
    // requester 0
    input  logic [15:0] m0_adr,
    input  logic [15:0] m0_dat_o,
    output logic [15:0] m0_dat_i,
    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    output logic        m0_ack,
    // requester 1
    input  logic [15:0] m1_adr,
    input  logic [15:0] m1_dat_o,
    output logic [15:0] m1_dat_i,
    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    output logic        m1_ack,
    // shared slave
    output logic [15:0] s_adr,
    output logic [15:0] s_dat_o,
    input  logic [15:0] s_dat_i,
    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    input  logic        s_ack,
    // status
    output logic [1:0]  gnt_o,
    output logic        to_flag_o,
    input  logic        to_clr_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'((TO_CYCLES == 0) ? 0 : TO_CYCLES - 1);

    state_t      state_reg;
    logic [1:0]  gnt_reg;
    logic        last_reg;
    logic [7:0]  cnt_reg;
    logic        to_ack_reg;
    logic        to_flag_reg;

    logic [15:0] m_adr [2];
    logic [15:0] m_dat [2];
    logic [1:0]  m_cyc;
    logic [1:0]  m_stb;
    logic [1:0]  m_we;
    logic [1:0]  req;
    logic [1:0]  ack_vec;
    logic        granted;
    logic        sel;
    logic        cur_req;
    logic        other_req;
    logic        mst_ack;
    logic        to_hit;

    assign m_adr[0] = m0_adr;
    assign m_adr[1] = m1_adr;
    assign m_dat[0] = m0_dat_o;
    assign m_dat[1] = m1_dat_o;
    assign m_cyc    = {m1_cyc, m0_cyc};
    assign m_stb    = {m1_stb, m0_stb};
    assign m_we     = {m1_we, m0_we};

    // gnt_reg is kept one-hot in lockstep with state_reg, so it doubles as the mux select
    assign granted   = |gnt_reg;
    assign sel       = gnt_reg[1];
    assign cur_req   = req[sel];
    assign other_req = req[~sel];
    assign mst_ack   = to_ack_reg | s_ack;
    assign to_hit    = (TO_CYCLES != 0) && (cnt_reg == TO_LAST);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign req[gi]     = m_cyc[gi] & m_stb[gi];
            assign ack_vec[gi] = gnt_reg[gi] & mst_ack;
        end
    endgenerate

    // stb is withheld during the synthetic timeout ack so the slave sees no new cycle
    assign s_adr   = granted ? m_adr[sel] : 16'h0000;
    assign s_dat_o = granted ? m_dat[sel] : 16'h0000;
    assign s_we    = granted & m_we[sel];
    assign s_cyc   = granted & m_cyc[sel];
    assign s_stb   = granted & ~to_ack_reg & m_stb[sel];

    assign m0_ack    = ack_vec[0];
    assign m1_ack    = ack_vec[1];
    assign m0_dat_i  = s_dat_i;
    assign m1_dat_i  = s_dat_i;
    assign gnt_o     = gnt_reg;
    assign to_flag_o = to_flag_reg;

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            state_reg   <= IDLE;
            gnt_reg     <= 2'b00;
            last_reg    <= 1'b1;
            cnt_reg     <= 8'd0;
            to_ack_reg  <= 1'b0;
            to_flag_reg <= 1'b0;
        end else begin
            if (to_clr_i) begin
                to_flag_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    cnt_reg    <= 8'd0;
                    to_ack_reg <= 1'b0;
                    if (req[0] && (!req[1] || last_reg)) begin
                        state_reg <= GNT0;
                        gnt_reg   <= 2'b01;
                    end else if (req[1]) begin
                        state_reg <= GNT1;
                        gnt_reg   <= 2'b10;
                    end
                end
                default: begin
                    cnt_reg <= 8'd0;
                    if (to_ack_reg) begin
                        to_ack_reg <= 1'b0;
                        last_reg   <= sel;
                        state_reg  <= IDLE;
                        gnt_reg    <= 2'b00;
                    end else if (s_ack) begin
                        // a real ack wins over a coincident timeout
                        last_reg <= sel;
                        if (other_req) begin
                            state_reg <= sel ? GNT0 : GNT1;
                            gnt_reg   <= sel ? 2'b01 : 2'b10;
                        end else if (!cur_req) begin
                            state_reg <= IDLE;
                            gnt_reg   <= 2'b00;
                        end
                    end else if (!cur_req) begin
                        state_reg <= IDLE;
                        gnt_reg   <= 2'b00;
                    end else if (to_hit) begin
                        to_ack_reg  <= 1'b1;
                        to_flag_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/wb_arbiter2.md
WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 SHALL have parameter TO_CYCLES, default 64, giving the number of granted cycles without ack before a timeout (range 0..255; 0 disables the timeout).
REQ-002 SHALL have port sys_clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port sys_rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port m0, if_wb.slave, 16-bit adr/dat: requester 0 (J1 code bus); fields adr, dat_o, dat_i, cyc, stb, we, ack.
REQ-005 SHALL have port m1, if_wb.slave, 16-bit adr/dat: requester 1 (J1 data bus); same fields as m0.
REQ-006 SHALL have port s, if_wb.master, 16-bit adr/dat: the shared single-port memory or I/O slave.
REQ-007 SHALL have port gnt_o, output, 2 bits: one-hot current grant (bit0 = m0, bit1 = m1); 2'b00 when idle.
REQ-008 SHALL have port to_flag_o, output, 1 bit: sticky timeout flag.
REQ-009 SHALL have port to_clr_i, input, 1 bit: synchronous clear of to_flag_o.

Function
REQ-010 SHALL treat a master as requesting when its cyc & stb is 1.
REQ-011 SHALL implement an FSM with states IDLE, GNT0 and GNT1, and a 1-bit register last (the master served most recently).
REQ-012 SHALL, in IDLE, go next cycle to GNT0 if only m0 requests, to GNT1 if only m1 requests, and, if both request, grant the master not equal to last.
REQ-013 SHALL stay in IDLE when there is no request; one-cycle arbitration latency from request to slave stb.
REQ-014 SHALL, in GNTx, route the adr, dat_o, we, cyc and stb of master x to s.
REQ-015 SHALL pass s.ack combinationally to master x only; the other master sees ack = 0.
REQ-016 SHALL route s.dat_i to both masters' dat_i unconditionally.
REQ-017 SHALL, on s.ack in GNTx, set last = x and then go to the other master's GNT state if it requests, otherwise stay in GNTx if x still requests, otherwise go to IDLE.
REQ-018 SHALL give round-robin alternation on every ack when both masters request continuously (m0 holds cyc constantly, so cyc hold SHALL NOT lock the grant).
REQ-019 SHALL return to IDLE on the next cycle, with no slave cycle issued, when master x drops its request in GNTx before ack (abort); last is unchanged.
REQ-020 SHALL hold s.cyc = s.stb = 0 and s.adr, s.dat_o and s.we = 0 in IDLE.
REQ-021 SHALL keep an 8-bit timeout counter that clears on entry to GNTx and on each ack, and increments every GNTx cycle without ack.
REQ-022 SHALL, when TO_CYCLES != 0 and the counter equals TO_CYCLES-1 with no ack, in the next cycle assert a 1-cycle ack to master x (data undefined) with s.stb = 0, set to_flag_o = 1, set last = x, and go to IDLE.
REQ-023 SHALL give the ack precedence over the timeout when s.ack and the timeout coincide; to_flag_o is not set.
REQ-024 SHALL give set precedence over to_clr_i when both occur in the same cycle.
REQ-025 SHALL reflect the state in gnt_o, registered and glitch-free.

Reset
REQ-026 SHALL, on sys_rst_ni = 0, immediately set state = IDLE, last = 1 (so m0 wins the first tie), counter = 0, to_flag_o = 0, gnt_o = 2'b00, and s.cyc = s.stb = 0.
REQ-027 SHALL, when reset is asserted mid-transfer, drop s.cyc/s.stb asynchronously and give no ack to any master.
REQ-028 SHALL begin arbitration on the first clock edge after reset deassertion.

Verification
REQ-029 SHALL cover: after reset, m0 reads adr 0x0010 with slave ack in 1 cycle -> gnt_o = 01 one cycle after stb, m0.ack = 1, m0.dat_i = slave data, m1.ack = 0.
REQ-030 SHALL cover: both masters request continuously for 6 acks -> grant sequence m0, m1, m0, m1, m0, m1.
REQ-031 SHALL cover: m1 writes 0xBEEF to adr 0x4000 while m0 is idle -> s.we = 1, s.adr = 0x4000, s.dat_o = 0xBEEF, then IDLE after ack.
REQ-032 SHALL cover: TO_CYCLES = 4 with the slave never acking m1 -> m1.ack pulses in the 5th granted cycle, to_flag_o = 1 until to_clr_i, then FSM IDLE.
REQ-033 SHALL cover: m0 drops stb in GNT0 before ack -> IDLE next cycle, no ack, last unchanged.
REQ-034 SHALL cover: reset asserted in GNT1 mid-wait -> gnt_o = 00 and s.stb = 0 without waiting for a clock edge; to_flag_o = 0.
